// File: rtl/rx_fcs_checker_if.sv
// GMII receive inputs and checked-frame outputs of the RX FCS checker.
// The master side is the PHY/stimulus; the slave side is the checker.
interface rx_fcs_checker_if #(
    parameter int OCT = 8
);
    logic           RX_DV;
    logic [OCT-1:0] RXD;
    logic           RX_ER;
    logic           rx_frame_data_v;
    logic [OCT-1:0] rx_frame_data;
    logic           rx_frame_end;
    logic           rx_frame_good;
    logic [15:0]    rx_frame_len;
    logic [15:0]    rx_crc_err_cnt;

    modport master (
        output RX_DV, RXD, RX_ER,
        input  rx_frame_data_v, rx_frame_data, rx_frame_end,
               rx_frame_good, rx_frame_len, rx_crc_err_cnt
    );

    modport slave (
        input  RX_DV, RXD, RX_ER,
        output rx_frame_data_v, rx_frame_data, rx_frame_end,
               rx_frame_good, rx_frame_len, rx_crc_err_cnt
    );
endinterface

// File: rtl/rx_fcs_checker.sv
// GMII receive front end: strips preamble/SFD, checks CRC-32, holds the
// last four bytes back so the FCS is never forwarded, and reports per-frame
// status (good, length) with a one-cycle end pulse.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for RX_DV with a preamble or SFD byte
// PREAMBLE | inside the preamble, waiting for SFD
// DATA     | frame bytes after SFD; CRC, length and delay line running
// DROP     | malformed start; ignore everything until RX_DV falls
module rx_fcs_checker #(
    parameter int             OCT     = 8,
    parameter logic [OCT-1:0] PRE     = 8'b10101010,
    parameter logic [OCT-1:0] SFD     = 8'b10101011,
    parameter int             MIN_LEN = 64,
    parameter int             MAX_LEN = 1518
) (
    input logic           RX_CLK,
    input logic           rst,
    rx_fcs_checker_if.slave gmii
);
    localparam logic [1:0]  S_IDLE     = 2'd0;
    localparam logic [1:0]  S_PREAMBLE = 2'd1;
    localparam logic [1:0]  S_DATA     = 2'd2;
    localparam logic [1:0]  S_DROP     = 2'd3;

    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] RESIDUE  = 32'hDEBB20E3;
    localparam logic [15:0] MIN16    = 16'(MIN_LEN);
    localparam logic [15:0] MAX16    = 16'(MAX_LEN);

    logic [1:0]            state;
    logic [31:0]           crc;
    logic [15:0]           cnt;
    logic                  err;
    // Cleared by reset, set once RX_DV is seen low: stops the tail of a
    // frame interrupted by reset from being taken as a new start.
    logic                  armed;
    logic [3:0][OCT-1:0]   dly;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [OCT-1:0] d);
        logic [31:0] r;
        r = c ^ {{(32-OCT){1'b0}}, d};
        for (int i = 0; i < OCT; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // Frame FSM, CRC/length tracking, delay line and registered outputs.
    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            state                <= S_IDLE;
            crc                  <= CRC_INIT;
            cnt                  <= '0;
            err                  <= 1'b0;
            armed                <= 1'b0;
            dly                  <= '0;
            gmii.rx_frame_data_v <= 1'b0;
            gmii.rx_frame_data   <= '0;
            gmii.rx_frame_end    <= 1'b0;
            gmii.rx_frame_good   <= 1'b0;
            gmii.rx_frame_len    <= '0;
            gmii.rx_crc_err_cnt  <= '0;
        end else begin
            gmii.rx_frame_data_v <= 1'b0;
            gmii.rx_frame_end    <= 1'b0;
            if (!gmii.RX_DV) begin
                armed <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (gmii.RX_DV && armed) begin
                        if (gmii.RXD == PRE) begin
                            state <= S_PREAMBLE;
                        end else if (gmii.RXD == SFD) begin
                            state <= S_DATA;
                            crc   <= CRC_INIT;
                            cnt   <= '0;
                            err   <= 1'b0;
                        end else begin
                            state <= S_DROP;
                        end
                    end
                end
                S_PREAMBLE: begin
                    if (!gmii.RX_DV) begin
                        state <= S_IDLE;
                    end else if (gmii.RXD == SFD) begin
                        state <= S_DATA;
                        crc   <= CRC_INIT;
                        cnt   <= '0;
                        err   <= 1'b0;
                    end else if (gmii.RXD != PRE) begin
                        state <= S_DROP;
                    end
                end
                S_DATA: begin
                    if (gmii.RX_DV) begin
                        dly <= {dly[2:0], gmii.RXD};
                        crc <= crc_next(crc, gmii.RXD);
                        if (cnt != 16'hFFFF) begin
                            cnt <= cnt + 16'd1;
                        end
                        if (gmii.RX_ER) begin
                            err <= 1'b1;
                        end
                        if (cnt >= 16'd4) begin
                            gmii.rx_frame_data_v <= 1'b1;
                            gmii.rx_frame_data   <= dly[3];
                        end
                    end else begin
                        state              <= S_IDLE;
                        gmii.rx_frame_end  <= 1'b1;
                        gmii.rx_frame_len  <= (cnt >= 16'd4) ? (cnt - 16'd4) : 16'd0;
                        gmii.rx_frame_good <= (crc == RESIDUE) && (cnt >= MIN16) &&
                                              (cnt <= MAX16) && !err;
                        if ((crc != RESIDUE) && (cnt >= 16'd4) &&
                            (gmii.rx_crc_err_cnt != 16'hFFFF)) begin
                            gmii.rx_crc_err_cnt <= gmii.rx_crc_err_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    if (!gmii.RX_DV) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rx_fcs_checker.sv
// Directed bench for rx_fcs_checker. Two instances share the same GMII
// stimulus: one with MIN_LEN=4, one with the default MIN_LEN=64. The
// expected outputs come from a frame-level model (byte lists, FCS computed
// over the payload and compared with the transmitted FCS field).
module tb_rx_fcs_checker;
    logic clk = 1'b0;
    logic rst;
    always #4 clk = ~clk;

    rx_fcs_checker_if ifa ();
    rx_fcs_checker_if ifb ();

    rx_fcs_checker #(.MIN_LEN(4)) dut_a (.RX_CLK(clk), .rst(rst), .gmii(ifa.slave));
    rx_fcs_checker                dut_b (.RX_CLK(clk), .rst(rst), .gmii(ifb.slave));

    localparam logic [7:0] PRE = 8'hAA;
    localparam logic [7:0] SFD = 8'hAB;

    int n_checks = 0;
    int n_fail   = 0;
    int min_len [2] = '{4, 64};

    // Expected outputs for the clock edge following the current drive.
    logic        exp_v    = 1'b0;
    logic [7:0]  exp_data = '0;
    logic        exp_end  = 1'b0;
    logic [15:0] exp_len  = '0;
    logic [1:0]  exp_good = '0;
    logic [15:0] exp_cnt  = '0;

    logic [7:0] frm[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] crc32_of(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, frm[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic drive(input logic dv, input logic [7:0] d, input logic er, input logic r);
        @(negedge clk);
        ifa.RX_DV = dv; ifa.RXD = d; ifa.RX_ER = er;
        ifb.RX_DV = dv; ifb.RXD = d; ifb.RX_ER = er;
        rst = r;
        exp_v   = 1'b0;
        exp_end = 1'b0;
        if (r) begin
            exp_data = '0; exp_len = '0; exp_good = '0; exp_cnt = '0;
        end
    endtask

    task automatic make_frame(input int n_total, input int seed);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < n_total - 4; i++) frm.push_back(8'(seed + i * 37));
        c = crc32_of(n_total - 4);
        frm.push_back(c[7:0]);   frm.push_back(c[15:8]);
        frm.push_back(c[23:16]); frm.push_back(c[31:24]);
    endtask

    // Sends frm with npre preamble bytes. er_at marks a byte with RX_ER,
    // rst_at pulses reset while that byte is on the wire (-1 = none).
    task automatic send(input int npre, input int er_at, input int rst_at);
        int  n;
        bit  had_er;
        bit  crc_ok;
        n = frm.size();
        had_er = 1'b0;
        for (int i = 0; i < npre; i++) drive(1'b1, PRE, 1'b0, 1'b0);
        drive(1'b1, SFD, 1'b0, 1'b0);
        for (int k = 0; k < n; k++) begin
            if (k == rst_at) begin
                drive(1'b1, frm[k], 1'b0, 1'b1);
                for (int j = k + 1; j < n; j++) drive(1'b1, frm[j], 1'b0, 1'b0);
                drive(1'b0, 8'h00, 1'b0, 1'b0);
                return;
            end
            drive(1'b1, frm[k], (k == er_at), 1'b0);
            if (k == er_at) had_er = 1'b1;
            if (k >= 4) begin
                exp_v    = 1'b1;
                exp_data = frm[k-4];
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        crc_ok  = (n >= 4) && (crc32_of(n - 4) == {frm[n-1], frm[n-2], frm[n-3], frm[n-4]});
        exp_end = 1'b1;
        exp_len = (n >= 4) ? 16'(n - 4) : 16'd0;
        for (int i = 0; i < 2; i++)
            exp_good[i] = crc_ok && (n >= min_len[i]) && (n <= 1518) && !had_er;
        if ((n >= 4) && !crc_ok && (exp_cnt != 16'hFFFF)) exp_cnt = exp_cnt + 16'd1;
    endtask

    // Reads outputs right after the edge that completes the last drive.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Per-cycle compare of both instances against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("a.data_v", ifa.rx_frame_data_v, exp_v);
            chk("a.data",   ifa.rx_frame_data,   exp_data);
            chk("a.end",    ifa.rx_frame_end,    exp_end);
            chk("a.good",   ifa.rx_frame_good,   exp_good[0]);
            chk("a.len",    ifa.rx_frame_len,    exp_len);
            chk("a.crc_cnt", ifa.rx_crc_err_cnt, exp_cnt);
            chk("b.data_v", ifb.rx_frame_data_v, exp_v);
            chk("b.data",   ifb.rx_frame_data,   exp_data);
            chk("b.end",    ifb.rx_frame_end,    exp_end);
            chk("b.good",   ifb.rx_frame_good,   exp_good[1]);
            chk("b.len",    ifb.rx_frame_len,    exp_len);
            chk("b.crc_cnt", ifb.rx_crc_err_cnt, exp_cnt);
        end
    end

    initial begin
        rst = 1'b1;
        ifa.RX_DV = 1'b0; ifa.RXD = 8'h00; ifa.RX_ER = 1'b0;
        ifb.RX_DV = 1'b0; ifb.RXD = 8'h00; ifb.RX_ER = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Pin the model's CRC against the well-known check value.
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("model.crc_check", crc32_of(9), 32'hCBF43926);

        // 1: "123456789" with its hand-written FCS.
        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};
        send(7, -1, -1);
        settle();
        chk("t1.a_good", ifa.rx_frame_good, 1'b1);
        chk("t1.a_len",  ifa.rx_frame_len, 16'd9);
        chk("t1.b_good", ifb.rx_frame_good, 1'b0);
        chk("t1.a_cnt",  ifa.rx_crc_err_cnt, 16'd0);

        // 2: same frame with '5' corrupted to '6'.
        frm[4] = 8'h36;
        send(7, -1, -1);
        settle();
        chk("t2.a_good", ifa.rx_frame_good, 1'b0);
        chk("t2.a_len",  ifa.rx_frame_len, 16'd9);
        chk("t2.a_cnt",  ifa.rx_crc_err_cnt, 16'd1);
        chk("t2.b_cnt",  ifb.rx_crc_err_cnt, 16'd1);

        // 3: valid-CRC runt of 60 bytes.
        make_frame(60, 5);
        send(7, -1, -1);
        settle();
        chk("t3.b_good", ifb.rx_frame_good, 1'b0);
        chk("t3.b_len",  ifb.rx_frame_len, 16'd56);
        chk("t3.a_good", ifa.rx_frame_good, 1'b1);
        chk("t3.b_cnt",  ifb.rx_crc_err_cnt, 16'd1);

        // 4: 64-byte frame with RX_ER on byte 20, then a clean one.
        make_frame(64, 17);
        send(7, 20, -1);
        settle();
        chk("t4.b_good_er", ifb.rx_frame_good, 1'b0);
        chk("t4.b_len_er",  ifb.rx_frame_len, 16'd60);
        make_frame(64, 99);
        send(7, -1, -1);
        settle();
        chk("t4.b_good", ifb.rx_frame_good, 1'b1);

        // 5: broken preamble goes to DROP; arbitrary bytes incl. PRE/SFD ignored.
        for (int i = 0; i < 3; i++) drive(1'b1, PRE, 1'b0, 1'b0);
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h12, 1'b0, 1'b0);
        drive(1'b1, SFD, 1'b0, 1'b0);
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        drive(1'b1, PRE, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        make_frame(70, 3);
        send(2, -1, -1);
        settle();
        chk("t5.b_good", ifb.rx_frame_good, 1'b1);
        chk("t5.b_len",  ifb.rx_frame_len, 16'd66);

        // 6: reset at byte 30 abandons the frame; the next frame is received.
        make_frame(80, 41);
        send(7, -1, 30);
        make_frame(72, 8);
        send(7, -1, -1);
        settle();
        chk("t6.b_good", ifb.rx_frame_good, 1'b1);
        chk("t6.b_len",  ifb.rx_frame_len, 16'd68);
        chk("t6.b_cnt",  ifb.rx_crc_err_cnt, 16'd0);

        // Short frame (SFD then 2 bytes): end with good=0, len=0, no count.
        frm = '{8'h01, 8'h02};
        send(7, -1, -1);
        settle();
        chk("short.a_len", ifa.rx_frame_len, 16'd0);
        chk("short.a_cnt", ifa.rx_crc_err_cnt, 16'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rx_fcs_checker.md
Name: rx_fcs_checker

Overview:
GMII receive front end that sits directly upstream of rx_ethernet in the RX datapath. It takes raw GMII bytes and strips the preamble and SFD. It computes CRC-32 over the frame, delays the data by 4 bytes so the FCS is never forwarded, and reports per-frame status (good/bad, length) at end of frame. rx_ethernet consumes its byte stream and its end/good status in place of raw RX_DV/RXD.

Parameters:
OCT, 8, byte width.
PRE, 8'b10101010, preamble byte as seen on RXD.
SFD, 8'b10101011, start-of-frame delimiter as seen on RXD.
MIN_LEN, 64, minimum good frame length in bytes after SFD, FCS included.
MAX_LEN, 1518, maximum good frame length in bytes after SFD, FCS included.

Ports:
RX_CLK  in  1  GMII receive clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
RX_DV  in  1  GMII receive data valid.
RXD  in  8  GMII receive data; RXD[0] is the first bit on the wire.
RX_ER  in  1  GMII receive error.
rx_frame_data_v  out  1  frame byte valid (FCS excluded).
rx_frame_data  out  8  frame byte, destination MAC first.
rx_frame_end  out  1  one-cycle pulse at end of frame.
rx_frame_good  out  1  status, qualified by rx_frame_end.
rx_frame_len  out  16  bytes forwarded (FCS excluded), qualified by rx_frame_end.
rx_crc_err_cnt  out  16  saturating count of frames ended with a CRC mismatch.

Behaviour:
- Reset: rst is synchronous, active-high; clock is RX_CLK. All outputs reset to 0, the FSM goes to IDLE, CRC = 32'hFFFFFFFF, byte counter = 0, error flag = 0. Reset mid-frame abandons the frame: no end pulse, and the remainder of that frame is ignored until RX_DV has been seen low.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - RX_DV=1 and RXD==PRE -> PREAMBLE.
  - RX_DV=1 and RXD==SFD -> DATA (short-preamble tolerance).
  - RX_DV=1 with any other byte -> DROP.
- PREAMBLE:
  - RXD==PRE -> stay.
  - RXD==SFD -> DATA; CRC := FFFFFFFF; counter := 0; error flag := 0.
  - Other byte -> DROP.
  - RX_DV=0 -> IDLE, no end pulse.
- DATA, each cycle with RX_DV=1:
  - Shift RXD into a 4-byte delay line.
  - Update the CRC with reflected CRC-32 (poly 32'hEDB88320, LSB first, no final inversion).
  - Counter += 1, saturating at 16'hFFFF.
  - RX_ER=1 sets the error flag.
  - If the counter before increment is >= 4, register the oldest delay-line byte onto rx_frame_data with rx_frame_data_v=1. Otherwise rx_frame_data_v=0.
  - Net effect: forwarded byte n appears in the cycle byte n+4 is sampled, one register stage.
- DATA, RX_DV=0 sampled:
  - rx_frame_end=1 for exactly one cycle.
  - rx_frame_len = counter-4, or 0 if counter < 4.
  - rx_frame_good = (CRC == 32'hDEBB20E3) and MIN_LEN <= counter <= MAX_LEN and error flag = 0.
  - If the CRC mismatches and counter >= 4, increment rx_crc_err_cnt, saturating at 16'hFFFF.
  - rx_frame_data_v=0; next state IDLE.
- DROP: wait for RX_DV=0 -> IDLE. No data, no end pulse, no counter change.
- Output hold: rx_frame_good and rx_frame_len hold their values until the next rx_frame_end. rx_frame_data holds its last value when rx_frame_data_v=0.
- Frames shorter than 4 bytes after SFD: no data is forwarded; the end pulse fires with good=0, len=0 and no CRC counter increment.
- Back-to-back frames need at least one RX_DV=0 cycle between them. A new preamble byte in the same cycle as the end pulse is not possible, because RX_DV=0 in that cycle.
- RX_DV held high for more than 65535 bytes: the counter saturates and the frame ends with good=0.

Test Plan:
1. MIN_LEN=4; preamble 7x PRE, SFD, "123456789" (31..39), FCS 26 39 F4 CB, then RX_DV=0 -> exactly 9 valid bytes 31..39 in order; rx_frame_end pulse with good=1, len=9; rx_crc_err_cnt=0.
2. Same as 1 with 0x35 corrupted to 0x36 -> 9 bytes forwarded; end with good=0, len=9; rx_crc_err_cnt=1.
3. Default MIN_LEN=64; valid-CRC 60-byte frame including FCS -> 56 bytes out; end with good=0 (runt), len=56; rx_crc_err_cnt unchanged.
4. 64-byte valid frame with RX_ER=1 on byte 20 -> 60 bytes out; good=0; rx_crc_err_cnt unchanged. The next valid frame after a 1-cycle gap -> good=1.
5. Preamble 3x PRE, then 0x00, then arbitrary bytes -> DROP; no rx_frame_data_v, no rx_frame_end. A following valid frame is received correctly.
6. rst asserted for 1 cycle at byte 30 of a frame -> all outputs 0 the next cycle; no end pulse for that frame. A subsequent frame is received with good=1.
